// File: rtl/pedo_pkg.sv
// Shared definitions for the pedometer datapath: sample width, default
// detector tuning and the step-detector state encoding.
package pedo_pkg;

   localparam int unsigned DATA_W        = 10;
   localparam int unsigned DEF_HI_THRESH = 600;
   localparam int unsigned DEF_LO_THRESH = 400;
   localparam int unsigned DEF_MIN_GAP   = 8;
   localparam int unsigned DEF_CNT_W     = 16;

   typedef logic [1:0] state_t;

   localparam state_t WARMUP = 2'd0;
   localparam state_t LOW    = 2'd1;
   localparam state_t HIGH   = 2'd2;

endpackage

// File: rtl/moving_avg4.sv
// 4-tap moving average over accepted samples. filt_next is the average the
// current sample would produce; filt_q holds the last committed average.
module moving_avg4 #(
   parameter int unsigned DATA_W = pedo_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              valid,
   input  logic [DATA_W-1:0] sample,
   output logic [DATA_W-1:0] filt_next,
   output logic [DATA_W-1:0] filt_q
);

   localparam int unsigned SUM_W = DATA_W + 2;

   // win_q[0] is the most recent accepted sample
   logic [DATA_W-1:0] win_q [3];
   logic [DATA_W-1:0] win_d [3];
   logic [DATA_W-1:0] filt_d;
   logic [SUM_W-1:0]  sum;

   assign sum = {2'b00, sample} + {2'b00, win_q[0]} + {2'b00, win_q[1]} + {2'b00, win_q[2]};
   assign filt_next = sum[SUM_W-1:2];

   always_comb begin
      win_d[0] = win_q[0];
      win_d[1] = win_q[1];
      win_d[2] = win_q[2];
      filt_d   = filt_q;
      if (clear) begin
         win_d[0] = '0;
         win_d[1] = '0;
         win_d[2] = '0;
         filt_d   = '0;
      end else if (valid) begin
         win_d[0] = sample;
         win_d[1] = win_q[0];
         win_d[2] = win_q[1];
         filt_d   = filt_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_q[0] <= '0;
         win_q[1] <= '0;
         win_q[2] <= '0;
         filt_q   <= '0;
      end else begin
         win_q[0] <= win_d[0];
         win_q[1] <= win_d[1];
         win_q[2] <= win_d[2];
         filt_q   <= filt_d;
      end
   end

endmodule

// File: rtl/step_detector.sv
// Pedometer step detector: smooths the node output, counts rising threshold
// crossings with hysteresis and a minimum inter-step gap, saturating count.
module step_detector
   import pedo_pkg::*;
#(
   parameter int unsigned DATA_W    = pedo_pkg::DATA_W,
   parameter int unsigned HI_THRESH = pedo_pkg::DEF_HI_THRESH,
   parameter int unsigned LO_THRESH = pedo_pkg::DEF_LO_THRESH,
   parameter int unsigned MIN_GAP   = pedo_pkg::DEF_MIN_GAP,
   parameter int unsigned CNT_W     = pedo_pkg::DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              node_valid,
   input  logic [DATA_W-1:0] node_result,
   input  logic              clear,
   output logic              step_pulse,
   output logic              suppressed_pulse,
   output logic [CNT_W-1:0]  step_count,
   output logic              count_sat,
   output logic [DATA_W-1:0] filt_out
);

   localparam int unsigned GAP_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

   localparam logic [DATA_W-1:0] HiT       = DATA_W'(HI_THRESH);
   localparam logic [DATA_W-1:0] LoT       = DATA_W'(LO_THRESH);
   localparam logic [GAP_W-1:0]  GapInit   = GAP_W'(MIN_GAP);
   localparam logic [CNT_W-1:0]  CntMax    = {CNT_W{1'b1}};
   localparam logic [2:0]        FillLast  = 3'd3;

   logic [DATA_W-1:0] filt_next;
   logic [DATA_W-1:0] filt_q;

   state_t           state_q, state_d;
   logic [2:0]       fill_q, fill_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             sat_q, sat_d;
   logic             step_q, step_d;
   logic             supp_q, supp_d;

   logic eval_low;
   logic rise;
   logic fall;

   moving_avg4 #(
      .DATA_W (DATA_W)
   ) u_avg (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .valid     (node_valid),
      .sample    (node_result),
      .filt_next (filt_next),
      .filt_q    (filt_q)
   );

   // The accept that completes the window is judged as if already in LOW
   assign eval_low = (state_q == LOW) || ((state_q == WARMUP) && (fill_q == FillLast));
   assign rise     = (filt_next >= HiT);
   assign fall     = (filt_next <= LoT);

   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      gap_d   = gap_q;
      count_d = count_q;
      sat_d   = sat_q;
      step_d  = 1'b0;
      supp_d  = 1'b0;
      if (clear) begin
         state_d = WARMUP;
         fill_d  = '0;
         gap_d   = '0;
         count_d = '0;
         sat_d   = 1'b0;
      end else if (node_valid) begin
         if (state_q == WARMUP) begin
            fill_d = fill_q + 3'd1;
         end
         if (gap_q != '0) begin
            gap_d = gap_q - 1'b1;
         end
         if (eval_low) begin
            if (rise) begin
               state_d = HIGH;
               if (gap_q == '0) begin
                  step_d = 1'b1;
                  gap_d  = GapInit;
                  if (count_q != CntMax) begin
                     count_d = count_q + 1'b1;
                  end
                  if (count_d == CntMax) begin
                     sat_d = 1'b1;
                  end
               end else begin
                  supp_d = 1'b1;
               end
            end else begin
               state_d = LOW;
            end
         end else if ((state_q == HIGH) && fall) begin
            state_d = LOW;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= WARMUP;
         fill_q  <= '0;
         gap_q   <= '0;
         count_q <= '0;
         sat_q   <= 1'b0;
         step_q  <= 1'b0;
         supp_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         gap_q   <= gap_d;
         count_q <= count_d;
         sat_q   <= sat_d;
         step_q  <= step_d;
         supp_q  <= supp_d;
      end
   end

   assign step_pulse       = step_q;
   assign suppressed_pulse = supp_q;
   assign step_count       = count_q;
   assign count_sat        = sat_q;
   assign filt_out         = filt_q;

endmodule

// File: tb/tb_step_detector.sv
// Self-checking bench for step_detector: behavioural model feeding a
// scoreboard queue, plus hand-derived vector tables for the corner cases.
module tb_step_detector;

   localparam int CW = 4;

   logic          clk;
   logic          rst_n;
   logic          node_valid;
   logic [9:0]    node_result;
   logic          clear;
   logic          step_pulse;
   logic          suppressed_pulse;
   logic [CW-1:0] step_count;
   logic          count_sat;
   logic [9:0]    filt_out;

   step_detector #(
      .CNT_W (CW)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .node_valid       (node_valid),
      .node_result      (node_result),
      .clear            (clear),
      .step_pulse       (step_pulse),
      .suppressed_pulse (suppressed_pulse),
      .step_count       (step_count),
      .count_sat        (count_sat),
      .filt_out         (filt_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      bit step;
      bit supp;
      int cnt;
      bit sat;
      int filt;
   } exp_t;

   typedef struct {
      bit v;
      int s;
      bit c;
      int es;
      int esu;
      int ecnt;
      int ef;
   } vec_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model state
   int m_w0, m_w1, m_w2, m_fill, m_state, m_gap, m_cnt, m_filt;
   bit m_sat;

   task automatic model_reset();
      m_w0 = 0; m_w1 = 0; m_w2 = 0;
      m_fill = 0; m_state = 0; m_gap = 0; m_cnt = 0; m_filt = 0; m_sat = 0;
   endtask

   task automatic model_step(input bit v, input int s, input bit c, output exp_t e);
      int  f;
      bit  judge;
      bit  counted;
      e.step = 0;
      e.supp = 0;
      counted = 0;
      if (c) begin
         model_reset();
      end else if (v) begin
         f = (s + m_w0 + m_w1 + m_w2) / 4;
         judge = (m_state == 1) || (m_state == 0 && m_fill == 3);
         if (m_state == 0) m_fill++;
         if (judge) begin
            if (f >= 600) begin
               if (m_gap == 0) begin
                  counted = 1;
                  e.step = 1;
                  if (m_cnt < 15) m_cnt++;
                  if (m_cnt == 15) m_sat = 1;
               end else begin
                  e.supp = 1;
               end
               m_state = 2;
            end else begin
               m_state = 1;
            end
         end else if (m_state == 2 && f <= 400) begin
            m_state = 1;
         end
         if (counted) m_gap = 8;
         else if (m_gap > 0) m_gap--;
         m_w2 = m_w1; m_w1 = m_w0; m_w0 = s;
         m_filt = f;
      end
      e.cnt  = m_cnt;
      e.sat  = m_sat;
      e.filt = m_filt;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one cycle, queue the model prediction, compare after the edge
   task automatic apply(input bit v, input int s, input bit c);
      exp_t e;
      exp_t got;
      int   sv;
      @(negedge clk);
      sv = s;
      node_valid  = v;
      node_result = sv[9:0];
      clear       = c;
      model_step(v, s, c, e);
      sbq.push_back(e);
      @(posedge clk);
      #1;
      got = sbq.pop_front();
      chk("sb_step_pulse", int'(step_pulse), int'(got.step));
      chk("sb_suppressed_pulse", int'(suppressed_pulse), int'(got.supp));
      chk("sb_step_count", int'(step_count), got.cnt);
      chk("sb_count_sat", int'(count_sat), int'(got.sat));
      chk("sb_filt_out", int'(filt_out), got.filt);
   endtask

   task automatic run_vec(input string tag, input vec_t t);
      apply(t.v, t.s, t.c);
      chk({tag, "_step"}, int'(step_pulse), t.es);
      chk({tag, "_supp"}, int'(suppressed_pulse), t.esu);
      chk({tag, "_cnt"}, int'(step_count), t.ecnt);
      chk({tag, "_filt"}, int'(filt_out), t.ef);
   endtask

   task automatic vec(input string tag, input bit v, input int s, input bit c,
                      input int es, input int esu, input int ecnt, input int ef);
      vec_t t;
      t.v = v; t.s = s; t.c = c; t.es = es; t.esu = esu; t.ecnt = ecnt; t.ef = ef;
      run_vec(tag, t);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_step"}, int'(step_pulse), 0);
      chk({tag, "_supp"}, int'(suppressed_pulse), 0);
      chk({tag, "_cnt"}, int'(step_count), 0);
      chk({tag, "_sat"}, int'(count_sat), 0);
      chk({tag, "_filt"}, int'(filt_out), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   vec_t tbl[17];
   vec_t gap_tbl[17];

   initial begin
      // Warmup, first step, idle hold, hysteresis and second step
      tbl[0]  = '{1, 1000, 0, 0, 0, 0, 250};
      tbl[1]  = '{1, 1000, 0, 0, 0, 0, 500};
      tbl[2]  = '{1, 1000, 0, 0, 0, 0, 750};
      tbl[3]  = '{1, 1000, 0, 1, 0, 1, 1000};
      tbl[4]  = '{0, 0,    0, 0, 0, 1, 1000};
      tbl[5]  = '{1, 500,  0, 0, 0, 1, 875};
      tbl[6]  = '{1, 500,  0, 0, 0, 1, 750};
      tbl[7]  = '{1, 500,  0, 0, 0, 1, 625};
      tbl[8]  = '{1, 500,  0, 0, 0, 1, 500};
      tbl[9]  = '{1, 300,  0, 0, 0, 1, 450};
      tbl[10] = '{1, 300,  0, 0, 0, 1, 400};
      tbl[11] = '{1, 300,  0, 0, 0, 1, 350};
      tbl[12] = '{1, 300,  0, 0, 0, 1, 300};
      tbl[13] = '{1, 800,  0, 0, 0, 1, 425};
      tbl[14] = '{1, 800,  0, 0, 0, 1, 550};
      tbl[15] = '{1, 800,  0, 1, 0, 2, 675};
      tbl[16] = '{1, 800,  0, 0, 0, 2, 800};

      // Gap rule: step at k, suppressed crossing at k+5, counted at k+11
      gap_tbl[0]  = '{1, 1000, 1, 0, 0, 0, 0};
      gap_tbl[1]  = '{1, 500,  0, 0, 0, 0, 125};
      gap_tbl[2]  = '{1, 500,  0, 0, 0, 0, 250};
      gap_tbl[3]  = '{1, 500,  0, 0, 0, 0, 375};
      gap_tbl[4]  = '{1, 500,  0, 0, 0, 0, 500};
      gap_tbl[5]  = '{1, 1000, 0, 1, 0, 1, 625};
      gap_tbl[6]  = '{1, 0,    0, 0, 0, 1, 500};
      gap_tbl[7]  = '{1, 0,    0, 0, 0, 1, 375};
      gap_tbl[8]  = '{1, 1023, 0, 0, 0, 1, 505};
      gap_tbl[9]  = '{1, 1023, 0, 0, 0, 1, 511};
      gap_tbl[10] = '{1, 1023, 0, 0, 1, 1, 767};
      gap_tbl[11] = '{1, 0,    0, 0, 0, 1, 767};
      gap_tbl[12] = '{1, 0,    0, 0, 0, 1, 511};
      gap_tbl[13] = '{1, 0,    0, 0, 0, 1, 255};
      gap_tbl[14] = '{1, 1023, 0, 0, 0, 1, 255};
      gap_tbl[15] = '{1, 1023, 0, 0, 0, 1, 511};
      gap_tbl[16] = '{1, 1023, 0, 1, 0, 2, 767};

      rst_n       = 1'b1;
      node_valid  = 1'b0;
      node_result = '0;
      clear       = 1'b0;
      model_reset();
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;

      for (int i = 0; i < 17; i++) run_vec("tbl", tbl[i]);
      for (int i = 0; i < 17; i++) run_vec("gap", gap_tbl[i]);

      // clear while HIGH with a valid sample: sample discarded, full warmup again
      vec("clr", 1, 1000, 1, 0, 0, 0, 0);
      vec("clr_w1", 1, 1000, 0, 0, 0, 0, 250);
      vec("clr_w2", 1, 1000, 0, 0, 0, 0, 500);
      vec("clr_w3", 1, 1000, 0, 0, 0, 0, 750);
      vec("clr_w4", 1, 1000, 0, 1, 0, 1, 1000);

      // Async reset while a step pulse is showing
      vec("rm_z1", 1, 0, 0, 0, 0, 1, 750);
      vec("rm_z2", 1, 0, 0, 0, 0, 1, 500);
      vec("rm_z3", 1, 0, 0, 0, 0, 1, 250);
      vec("rm_z4", 1, 0, 0, 0, 0, 1, 0);
      vec("rm_z5", 1, 0, 0, 0, 0, 1, 0);
      vec("rm_z6", 1, 0, 0, 0, 0, 1, 0);
      vec("rm_h1", 1, 1000, 0, 0, 0, 1, 250);
      vec("rm_h2", 1, 1000, 0, 0, 0, 1, 500);
      vec("rm_h3", 1, 1000, 0, 1, 0, 2, 750);
      #1 rst_n = 1'b0;
      #1;
      chk_all_zero("midreset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // Saturation with a 4-bit counter
      vec("sat_clr", 1, 0, 1, 0, 0, 0, 0);
      for (int n = 0; n < 16; n++) begin
         for (int j = 0; j < 5; j++) apply(1, 0, 0);
         for (int j = 0; j < 4; j++) begin
            apply(1, 1000, 0);
            if (j == 2) begin
               chk("sat_pulse", int'(step_pulse), 1);
               chk("sat_cnt", int'(step_count), (n + 1 > 15) ? 15 : n + 1);
               chk("sat_flag", int'(count_sat), (n >= 14) ? 1 : 0);
            end
         end
      end
      vec("sat_clear", 1, 0, 1, 0, 0, 0, 0);
      chk("sat_flag_cleared", int'(count_sat), 0);

      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
